// File: rtl/usb_fs_pkg.sv
// Shared constants, state enum and byte-serial CRC helpers for the USB FS receive path.
package usb_fs_pkg;

  localparam logic [1:0] PID_CLASS_SPECIAL = 2'b00;
  localparam logic [1:0] PID_CLASS_TOKEN   = 2'b01;
  localparam logic [1:0] PID_CLASS_HSHK    = 2'b10;
  localparam logic [1:0] PID_CLASS_DATA    = 2'b11;

  localparam logic [4:0]  CRC5_POLY       = 5'b00101;
  localparam logic [4:0]  CRC5_SEED       = 5'b11111;
  localparam logic [4:0]  CRC5_RESIDUAL   = 5'b01100;
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_SEED      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL  = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_HSHK,
    ST_ERR
  } parser_state_t;

  // Register kept with x^(n-1) in the MSB; wire bits enter LSB-first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[4] ^ data[i]) c = {c[3:0], 1'b0} ^ CRC5_POLY;
      else                c = {c[3:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_fs_rx_pkt_parser_if.sv
// Byte stream from the line decoder and packet strobes/fields toward the protocol engines.
interface usb_fs_rx_pkt_parser_if;
  logic        rx_sop;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        rx_eop;
  logic        rx_err;

  logic        rx_pkt_start;
  logic        rx_pkt_end;
  logic        rx_pkt_valid;
  logic [3:0]  rx_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_endp;
  logic [10:0] rx_frame_num;
  logic        rx_data_put;
  logic [7:0]  rx_data;

  modport master (
    output rx_sop, rx_byte_valid, rx_byte, rx_eop, rx_err,
    input  rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp,
           rx_frame_num, rx_data_put, rx_data
  );

  modport slave (
    input  rx_sop, rx_byte_valid, rx_byte, rx_eop, rx_err,
    output rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp,
           rx_frame_num, rx_data_put, rx_data
  );
endinterface

// File: rtl/usb_fs_crc16_byte.sv
// Byte-serial CRC16 (x^16+x^15+x^2+1) register; match compares the next value to the residual.
module usb_fs_crc16_byte
  import usb_fs_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       update,
  input  logic [7:0] data,
  output logic       match
);

  logic [15:0] crc_reg;
  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc_reg;
    if (init)        crc_next = CRC16_SEED;
    else if (update) crc_next = crc16_byte(crc_reg, data);
  end

  // Looking at the next value lets a byte coinciding with EOP still count.
  assign match = (crc_next == CRC16_RESIDUAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_reg <= CRC16_SEED;
    else          crc_reg <= crc_next;
  end

endmodule

// File: rtl/usb_fs_rx_pkt_parser.sv
// USB full-speed receive packet parser: framed bytes in, packet strobes and fields out.
// Define USB_RX_CRC_CHECK_EN to build the CRC5/CRC16 checks that gate rx_pkt_valid.
module usb_fs_rx_pkt_parser
  import usb_fs_pkg::*;
#(
  parameter int MAX_PKT_BYTES = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  usb_fs_rx_pkt_parser_if.slave bus
);

  localparam int               CNT_W   = $clog2(MAX_PKT_BYTES + 4);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_BYTES + 3);

  parser_state_t    state_reg, state_next, pid_state, eff_state;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             abort, byte_ok, verdict, crc5_ok, crc16_ok;

  logic        pkt_start_reg, pkt_end_reg, pkt_valid_reg, data_put_reg;
  logic        pkt_start_next, pkt_end_next, pkt_valid_next, data_put_next;
  logic [7:0]  data_reg, data_next;
  logic [3:0]  pid_reg, pid_next;
  logic [6:0]  addr_reg, addr_next;
  logic [3:0]  endp_reg, endp_next;
  logic [10:0] frame_reg, frame_next;

  assign abort   = bus.rx_err | bus.rx_sop;
  assign byte_ok = bus.rx_byte_valid & ~abort;

  always_comb begin
    pid_state = ST_ERR;
    if (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]) begin
      case (bus.rx_byte[1:0])
        PID_CLASS_TOKEN: pid_state = ST_TOKEN;
        PID_CLASS_DATA:  pid_state = ST_DATA;
        PID_CLASS_HSHK:  pid_state = ST_HSHK;
        default:         pid_state = ST_ERR;
      endcase
    end
  end

  // State the packet would be judged in if EOP arrives together with the PID byte.
  assign eff_state = (state_reg == ST_PID && bus.rx_byte_valid) ? pid_state : state_reg;

  // The count saturates; the overflow flag remembers that bytes were dropped.
  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (bus.rx_sop) begin
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (bus.rx_byte_valid && state_reg != ST_IDLE) begin
      if (cnt_reg == CNT_MAX) ovf_next = 1'b1;
      else                    cnt_next = cnt_reg + 1'b1;
    end
  end

`ifdef USB_RX_CRC_CHECK_EN
  logic [4:0] crc5_reg, crc5_next;
  logic       crc5_update;

  assign crc5_update = (state_reg == ST_TOKEN) & bus.rx_byte_valid;
  assign crc5_next   = crc5_update ? crc5_byte(crc5_reg, bus.rx_byte) : crc5_reg;
  assign crc5_ok     = (crc5_next == CRC5_RESIDUAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         crc5_reg <= CRC5_SEED;
    else if (bus.rx_sop)  crc5_reg <= CRC5_SEED;
    else                  crc5_reg <= crc5_next;
  end

  usb_fs_crc16_byte u_crc16 (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (bus.rx_sop),
    .update  ((state_reg == ST_DATA) & bus.rx_byte_valid),
    .data    (bus.rx_byte),
    .match   (crc16_ok)
  );
`else
  assign crc5_ok  = 1'b1;
  assign crc16_ok = 1'b1;
`endif

  always_comb begin
    verdict = 1'b0;
    if (!abort) begin
      case (eff_state)
        ST_TOKEN: verdict = (cnt_next == CNT_W'(3)) && crc5_ok;
        ST_DATA:  verdict = !ovf_next && (cnt_next >= CNT_W'(3)) && crc16_ok;
        ST_HSHK:  verdict = (cnt_next == CNT_W'(1));
        default:  verdict = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.rx_sop) state_next = ST_PID;
      default: begin
        if (bus.rx_eop)                                  state_next = ST_IDLE;
        else if (abort)                                  state_next = ST_ERR;
        else if (state_reg == ST_PID && bus.rx_byte_valid) state_next = pid_state;
      end
    endcase
  end

  always_comb begin
    pkt_start_next = (state_reg == ST_IDLE) && bus.rx_sop;
    pkt_end_next   = (state_reg != ST_IDLE) && bus.rx_eop;
    pkt_valid_next = pkt_end_next && verdict;
    data_put_next  = (state_reg == ST_DATA) && byte_ok && (cnt_reg < CNT_MAX);
    data_next      = data_put_next ? bus.rx_byte : data_reg;
    pid_next       = pid_reg;
    addr_next      = addr_reg;
    endp_next      = endp_reg;
    frame_next     = frame_reg;
    if (state_reg == ST_PID && byte_ok) pid_next = bus.rx_byte[3:0];
    if (state_reg == ST_TOKEN && byte_ok) begin
      if (cnt_reg == CNT_W'(1)) begin
        addr_next       = bus.rx_byte[6:0];
        endp_next[0]    = bus.rx_byte[7];
        frame_next[7:0] = bus.rx_byte;
      end else if (cnt_reg == CNT_W'(2)) begin
        endp_next[3:1]   = bus.rx_byte[2:0];
        frame_next[10:8] = bus.rx_byte[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_start_reg <= 1'b0;
      pkt_end_reg   <= 1'b0;
      pkt_valid_reg <= 1'b0;
      data_put_reg  <= 1'b0;
      data_reg      <= '0;
      pid_reg       <= '0;
      addr_reg      <= '0;
      endp_reg      <= '0;
      frame_reg     <= '0;
    end else begin
      pkt_start_reg <= pkt_start_next;
      pkt_end_reg   <= pkt_end_next;
      pkt_valid_reg <= pkt_valid_next;
      data_put_reg  <= data_put_next;
      data_reg      <= data_next;
      pid_reg       <= pid_next;
      addr_reg      <= addr_next;
      endp_reg      <= endp_next;
      frame_reg     <= frame_next;
    end
  end

  assign bus.rx_pkt_start = pkt_start_reg;
  assign bus.rx_pkt_end   = pkt_end_reg;
  assign bus.rx_pkt_valid = pkt_valid_reg;
  assign bus.rx_data_put  = data_put_reg;
  assign bus.rx_data      = data_reg;
  assign bus.rx_pid       = pid_reg;
  assign bus.rx_addr      = addr_reg;
  assign bus.rx_endp      = endp_reg;
  assign bus.rx_frame_num = frame_reg;

endmodule
